lift_request_ctrl: RTL and testbench

- Producer side of the lift display interface: captures floor-call buttons and runs the car position/direction state machine.
- Drives the display driver inputs: current floor E, scroll enable enable_SB, direction opcion, number enable enable_NUM.
- Sits between the board push-buttons and the 7-segment animation block; one instance per car.

---
 rtl/lift_pkg.sv | 19 +
 rtl/btn_debounce.sv | 57 +++++
 rtl/lift_request_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lift_request_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared encodings for the lift request controller.
//   state_e  : car state (idle, moving up, moving down, door open)
//   FLOOR_W  : width of the floor index
//   DIR_UP / DIR_DOWN : values of the direction output
package lift_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2,
      S_DOOR = 2'd3
   } state_e;

   localparam int FLOOR_W = 3;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Per-button input conditioning: 2-FF synchronizer, stable counter and a
// registered one-cycle pulse on each accepted 0->1 transition.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw button, asynchronous to clk_i
//   press_o : one-cycle pulse after the button has been stably high DEB_CYC samples
module btn_debounce #(
   parameter int unsigned DEB_CYC = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CntW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronized input disagrees with the
   // accepted level; any agreeing sample restarts it.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntW'(DEB_CYC - 1)) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/lift_request_ctrl.sv
// Lift car controller: latches floor calls and runs the car position and
// direction state machine feeding the display driver.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   btn        : raw floor-call buttons, active-high
//   E          : current floor index
//   enable_SB  : high while the car is moving
//   opcion     : direction, 1 = up, 0 = down (holds last direction)
//   enable_NUM : high while idle or door open
//   pending    : outstanding calls, one bit per floor
module lift_request_ctrl
   import lift_pkg::*;
#(
   parameter int unsigned NUM_FLOORS = 6,
   parameter int unsigned DEB_CYC    = 1000000,
   parameter int unsigned FLOOR_CYC  = 100000000,
   parameter int unsigned DOOR_CYC   = 300000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] btn,
   output logic [FLOOR_W-1:0]    E,
   output logic                  enable_SB,
   output logic                  opcion,
   output logic                  enable_NUM,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int unsigned FloorCntW = $clog2(FLOOR_CYC + 1);
   localparam int unsigned DoorCntW  = $clog2(DOOR_CYC + 1);

   function automatic logic [NUM_FLOORS-1:0] floor_oh(input logic [FLOOR_W-1:0] e);
      for (int f = 0; f < NUM_FLOORS; f++) floor_oh[f] = (FLOOR_W'(f) == e);
   endfunction

   function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [NUM_FLOORS-1:0] p,
                                                         input logic [FLOOR_W-1:0]    e);
      for (int f = 0; f < NUM_FLOORS; f++) above_mask[f] = p[f] && (FLOOR_W'(f) > e);
   endfunction

   function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [NUM_FLOORS-1:0] p,
                                                         input logic [FLOOR_W-1:0]    e);
      for (int f = 0; f < NUM_FLOORS; f++) below_mask[f] = p[f] && (FLOOR_W'(f) < e);
   endfunction

   logic [NUM_FLOORS-1:0] press;

   for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
      btn_debounce #(
         .DEB_CYC (DEB_CYC)
      ) u_deb (
         .clk_i   (clk),
         .rst_ni  (reset),
         .btn_i   (btn[g]),
         .press_o (press[g])
      );
   end

   state_e                state_q, state_d;
   logic [FLOOR_W-1:0]    e_q, e_d, e_step;
   logic                  opcion_q, opcion_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d, clr, absorb_mask;
   logic [FloorCntW-1:0]  floor_cnt_q, floor_cnt_d;
   logic [DoorCntW-1:0]   door_cnt_q, door_cnt_d;
   logic                  en_sb_q, en_num_q, moving_d, any_above, any_below, absorb;

   assign any_above   = |above_mask(pending_q, e_q);
   assign any_below   = |below_mask(pending_q, e_q);
   // A call for the floor whose door is already open is served by keeping it open.
   assign absorb_mask = (state_q == S_DOOR) ? floor_oh(e_q) : '0;
   assign absorb      = |(press & absorb_mask);

   always_comb begin
      state_d     = state_q;
      e_d         = e_q;
      e_step      = e_q;
      opcion_d    = opcion_q;
      floor_cnt_d = '0;
      door_cnt_d  = '0;
      clr         = '0;
      unique case (state_q)
         S_IDLE: begin
            if (|(pending_q & floor_oh(e_q))) begin
               clr     = floor_oh(e_q);
               state_d = S_DOOR;
            end else if (any_above && (opcion_q || !any_below)) begin
               state_d  = S_UP;
               opcion_d = DIR_UP;
            end else if (any_below) begin
               state_d  = S_DOWN;
               opcion_d = DIR_DOWN;
            end
         end
         S_UP, S_DOWN: begin
            if (floor_cnt_q == FloorCntW'(FLOOR_CYC - 1)) begin
               e_step = (state_q == S_UP) ? e_q + FLOOR_W'(1) : e_q - FLOOR_W'(1);
               e_d    = e_step;
               if (|(pending_q & floor_oh(e_step))) begin
                  clr     = floor_oh(e_step);
                  state_d = S_DOOR;
               end else if ((state_q == S_UP) ? !(|above_mask(pending_q, e_step))
                                              : !(|below_mask(pending_q, e_step))) begin
                  state_d = S_IDLE;
               end
            end else begin
               floor_cnt_d = floor_cnt_q + FloorCntW'(1);
            end
         end
         S_DOOR: begin
            if (absorb) begin
               door_cnt_d = '0;
            end else if (door_cnt_q == DoorCntW'(DOOR_CYC - 1)) begin
               if (opcion_q ? any_above : any_below) begin
                  state_d = opcion_q ? S_UP : S_DOWN;
               end else if (opcion_q ? any_below : any_above) begin
                  state_d  = opcion_q ? S_DOWN : S_UP;
                  opcion_d = ~opcion_q;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               door_cnt_d = door_cnt_q + DoorCntW'(1);
            end
         end
      endcase
      // A new press outranks a same-cycle clear except when absorbed by an open door.
      pending_d = (pending_q & ~clr) | (press & ~absorb_mask);
      moving_d  = (state_d == S_UP) || (state_d == S_DOWN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         e_q         <= '0;
         opcion_q    <= DIR_UP;
         pending_q   <= '0;
         floor_cnt_q <= '0;
         door_cnt_q  <= '0;
         en_sb_q     <= 1'b0;
         en_num_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         e_q         <= e_d;
         opcion_q    <= opcion_d;
         pending_q   <= pending_d;
         floor_cnt_q <= floor_cnt_d;
         door_cnt_q  <= door_cnt_d;
         en_sb_q     <= moving_d;
         en_num_q    <= !moving_d;
      end
   end

   assign E          = e_q;
   assign enable_SB  = en_sb_q;
   assign enable_NUM = en_num_q;
   assign opcion     = opcion_q;
   assign pending    = pending_q;

   a_no_up_from_top: assert property (@(posedge clk) disable iff (!reset)
      !(state_q == S_UP && e_q == FLOOR_W'(NUM_FLOORS - 1)));
   a_no_down_from_0: assert property (@(posedge clk) disable iff (!reset)
      !(state_q == S_DOWN && e_q == '0));

endmodule

// File: tb/tb_lift_request_ctrl.sv
module tb_lift_request_ctrl;
   import lift_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] btn = '0;
   logic [2:0] e_o;
   logic       en_sb, en_num, opcion;
   logic [5:0] pending;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   lift_request_ctrl #(
      .NUM_FLOORS (6),
      .DEB_CYC    (4),
      .FLOOR_CYC  (16),
      .DOOR_CYC   (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn),
      .E          (e_o),
      .enable_SB  (en_sb),
      .opcion     (opcion),
      .enable_NUM (en_num),
      .pending    (pending)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cyc %0d): got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int k);
      while (cyc < k) step();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      btn   = '0;
      repeat (3) step();
      check_eq("rst_E", e_o, 0);
      check_eq("rst_pending", pending, 0);
      check_eq("rst_opcion", opcion, 1);
      check_eq("rst_en_num", en_num, 1);
      check_eq("rst_en_sb", en_sb, 0);
      reset = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      // Single call to floor 3 from floor 0.
      do_reset();
      btn[3] = 1'b1;
      run_to(6);  check_eq("t1_pend_early", pending, 6'b000000);
      run_to(7);  check_eq("t1_pend_set", pending, 6'b001000);
      check_eq("t1_idle_sb", en_sb, 0);
      run_to(8);  check_eq("t1_sb", en_sb, 1);
      check_eq("t1_opcion", opcion, 1);
      check_eq("t1_num", en_num, 0);
      run_to(10); btn[3] = 1'b0;
      run_to(23); check_eq("t1_E0", e_o, 0);
      run_to(24); check_eq("t1_E1", e_o, 1);
      run_to(40); check_eq("t1_E2", e_o, 2);
      run_to(56); check_eq("t1_E3", e_o, 3);
      check_eq("t1_pend_clr", pending, 0);
      check_eq("t1_door_num", en_num, 1);
      check_eq("t1_door_sb", en_sb, 0);
      check_eq("t1_door_st", dut.state_q, S_DOOR);
      run_to(63); check_eq("t1_door_last", dut.state_q, S_DOOR);
      run_to(64); check_eq("t1_idle", dut.state_q, S_IDLE);

      // Short glitch is rejected.
      do_reset();
      btn[2] = 1'b1;
      run_to(3);  btn[2] = 1'b0;
      run_to(7);  check_eq("t2_pend7", pending, 0);
      run_to(12); check_eq("t2_pend", pending, 0);
      check_eq("t2_E", e_o, 0);
      check_eq("t2_sb", en_sb, 0);
      check_eq("t2_st", dut.state_q, S_IDLE);

      // Call to 4, intermediate call to 2 picked up on the way.
      cyc = 0;
      btn[4] = 1'b1;
      run_to(8);  btn[4] = 1'b0;
      check_eq("t3_sb", en_sb, 1);
      run_to(20); btn[2] = 1'b1;
      run_to(27); check_eq("t3_pend", pending, 6'b010100);
      run_to(28); btn[2] = 1'b0;
      run_to(40); check_eq("t3_E2", e_o, 2);
      check_eq("t3_pend2", pending, 6'b010000);
      check_eq("t3_num2", en_num, 1);
      run_to(47); check_eq("t3_door_sb", en_sb, 0);
      run_to(48); check_eq("t3_leave_sb", en_sb, 1);
      check_eq("t3_leave_op", opcion, 1);
      run_to(64); check_eq("t3_E3", e_o, 3);
      run_to(80); check_eq("t3_E4", e_o, 4);
      check_eq("t3_pend4", pending, 0);
      run_to(87); check_eq("t3_door4", dut.state_q, S_DOOR);
      run_to(88); check_eq("t3_idle", dut.state_q, S_IDLE);
      check_eq("t3_op_end", opcion, 1);
      check_eq("t3_num_end", en_num, 1);

      // Calls above and below at once: up first, then reverse.
      run_to(90);
      cyc = 0;
      btn = 6'b100010;
      run_to(7);  check_eq("t4_pend", pending, 6'b100010);
      check_eq("t4_E", e_o, 4);
      run_to(8);  btn = '0;
      check_eq("t4_sb", en_sb, 1);
      check_eq("t4_op_up", opcion, 1);
      run_to(24); check_eq("t4_E5", e_o, 5);
      check_eq("t4_pend5", pending, 6'b000010);
      check_eq("t4_num5", en_num, 1);
      run_to(31); check_eq("t4_door_sb", en_sb, 0);
      run_to(32); check_eq("t4_rev_sb", en_sb, 1);
      check_eq("t4_op_dn", opcion, 0);
      run_to(48); check_eq("t4_E4b", e_o, 4);
      check_eq("t4_pass_sb", en_sb, 1);
      run_to(96); check_eq("t4_E1", e_o, 1);
      check_eq("t4_pend_end", pending, 0);
      check_eq("t4_num1", en_num, 1);
      run_to(104); check_eq("t4_idle", dut.state_q, S_IDLE);
      check_eq("t4_op_end", opcion, 0);

      // Press for the open-door floor restarts the door timer.
      do_reset();
      btn[2] = 1'b1;
      run_to(8);  btn[2] = 1'b0;
      run_to(40); check_eq("t5_E2", e_o, 2);
      btn[2] = 1'b1;
      run_to(47); check_eq("t5_pend_abs", pending, 0);
      run_to(48); btn[2] = 1'b0;
      run_to(50); check_eq("t5_door50", dut.state_q, S_DOOR);
      run_to(54); check_eq("t5_door54", dut.state_q, S_DOOR);
      check_eq("t5_pend54", pending, 0);
      run_to(55); check_eq("t5_idle", dut.state_q, S_IDLE);

      // Reset while travelling between floors 2 and 3.
      run_to(58);
      cyc = 0;
      btn[4] = 1'b1;
      run_to(8);  btn[4] = 1'b0;
      run_to(15); check_eq("t6_E_pre", e_o, 2);
      check_eq("t6_sb_pre", en_sb, 1);
      reset = 1'b0;
      #2;
      check_eq("t6_E", e_o, 0);
      check_eq("t6_pend", pending, 0);
      check_eq("t6_num", en_num, 1);
      check_eq("t6_sb", en_sb, 0);
      check_eq("t6_op", opcion, 1);
      step();
      step();
      reset = 1'b1;
      cyc = 0;
      run_to(20);
      check_eq("t6_st", dut.state_q, S_IDLE);
      check_eq("t6_E_after", e_o, 0);
      check_eq("t6_pend_after", pending, 0);
      check_eq("t6_sb_after", en_sb, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
